// File: rtl/frame_update_scheduler_pkg.sv
// rtl/frame_update_scheduler_pkg.sv - shared state encoding and defaults for the frame update scheduler
package frame_update_scheduler_pkg;

  // default width of the lane index (covers up to 8 lanes)
  localparam int LANE_W_DEF = 3;

  // ST_GAP is the one idle cycle between consecutive lane requests
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FROG  = 3'd1,
    ST_LANE  = 3'd2,
    ST_GAP   = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/frame_update_scheduler_vsync_edge_sync.sv
// rtl/frame_update_scheduler_vsync_edge_sync.sv - two-flop vsync synchroniser with falling-edge pulse
module vsync_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic fall
);

  logic meta;
  logic sync;
  logic sync_d;

  // vsync idles high, so the chain resets to 1 to avoid a false edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      meta   <= vsync;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign fall = sync_d & ~sync;

endmodule

// File: rtl/frame_update_scheduler.sv
// rtl/frame_update_scheduler.sv - per-frame frog/lane/collision update sequencer; optional FRAME_UPDATE_WATCHDOG_EN
module frame_update_scheduler
  import frame_update_scheduler_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int LANE_W    = LANE_W_DEF,
  parameter int TICK_DIV  = 2,
  parameter int WDOG_CYC  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              pause,
  output logic              frog_req,
  input  logic              frog_ack,
  output logic              lane_req,
  output logic [LANE_W-1:0] lane_idx,
  input  logic              lane_ack,
  input  logic              collide,
  output logic              busy,
  output logic              frame_done,
  output logic              hit,
  output logic              overrun,
  output logic [15:0]       tick_cnt
`ifdef FRAME_UPDATE_WATCHDOG_EN
  ,
  output logic              wdog_err
`endif
);

  state_t     state;
  logic       vs_fall;
  logic [7:0] div_cnt;
  logic       div_wrap;
  logic       tick;
  logic       wdog_to;
  logic       frog_go;
  logic       lane_go;
  logic       last_lane;

  vsync_edge_sync u_vsync (
    .clk   (clk),
    .rst_n (rst_n),
    .vsync (vsync),
    .fall  (vs_fall)
  );

  assign div_wrap  = (div_cnt == 8'(TICK_DIV - 1));
  assign tick      = vs_fall & ~pause & div_wrap;
  assign last_lane = (lane_idx == LANE_W'(NUM_LANES - 1));

  // frame divider: advances on each vsync fall unless paused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= 8'd0;
    end else if (vs_fall && !pause) begin
      div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
    end
  end

`ifdef FRAME_UPDATE_WATCHDOG_EN
  logic [7:0] wcnt;
  logic       any_req;
  logic       step_ack;

  assign any_req  = frog_req | lane_req;
  assign wdog_to  = any_req && (wcnt == 8'(WDOG_CYC - 1));
  assign step_ack = (frog_req & frog_ack) | (lane_req & lane_ack) | wdog_to;

  // wait counter restarts on every completed step and whenever no request is out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= 8'd0;
      wdog_err <= 1'b0;
    end else begin
      wcnt <= (any_req && !step_ack) ? wcnt + 8'd1 : 8'd0;
      if (wdog_to) wdog_err <= 1'b1;
    end
  end
`else
  assign wdog_to = 1'b0;
`endif

  assign frog_go = frog_ack | wdog_to;
  assign lane_go = lane_ack | wdog_to;

  // sequencer: one frog step, NUM_LANES lane steps with a gap between, check, done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      frog_req   <= 1'b0;
      lane_req   <= 1'b0;
      lane_idx   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      hit        <= 1'b0;
      overrun    <= 1'b0;
      tick_cnt   <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      if (tick && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            frog_req <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_FROG;
          end
        end
        ST_FROG: begin
          if (frog_go) begin
            frog_req <= 1'b0;
            lane_req <= 1'b1;
            lane_idx <= '0;
            state    <= ST_LANE;
          end
        end
        ST_LANE: begin
          if (lane_go) begin
            lane_req <= 1'b0;
            if (last_lane) begin
              state <= ST_CHECK;
            end else begin
              lane_idx <= lane_idx + 1'b1;
              state    <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          lane_req <= 1'b1;
          state    <= ST_LANE;
        end
        ST_CHECK: begin
          hit        <= collide;
          frame_done <= 1'b1;
          tick_cnt   <= tick_cnt + 16'd1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          busy     <= 1'b0;
          lane_idx <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// tb/tb_frame_update_scheduler.sv - scoreboard bench for frame_update_scheduler
module tb_frame_update_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pause, vsync_a, vsync_b;
  logic        frog_req_a, frog_ack_a, lane_req_a, lane_ack_a, collide_a;
  logic [2:0]  lane_idx_a;
  logic        busy_a, frame_done_a, hit_a, overrun_a;
  logic [15:0] tick_cnt_a;
  logic        frog_req_b, frog_ack_b, lane_req_b, lane_ack_b;
  logic [2:0]  lane_idx_b;
  logic        busy_b, frame_done_b, hit_b, overrun_b;
  logic [15:0] tick_cnt_b;
`ifdef FRAME_UPDATE_WATCHDOG_EN
  logic        wdog_err_a, wdog_err_b;
`endif

  frame_update_scheduler #(.NUM_LANES(8), .LANE_W(3), .TICK_DIV(1), .WDOG_CYC(255)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .vsync(vsync_a), .pause(pause),
    .frog_req(frog_req_a), .frog_ack(frog_ack_a), .lane_req(lane_req_a), .lane_idx(lane_idx_a),
    .lane_ack(lane_ack_a), .collide(collide_a), .busy(busy_a), .frame_done(frame_done_a),
    .hit(hit_a), .overrun(overrun_a), .tick_cnt(tick_cnt_a)
`ifdef FRAME_UPDATE_WATCHDOG_EN
    , .wdog_err(wdog_err_a)
`endif
  );

  frame_update_scheduler #(.NUM_LANES(8), .LANE_W(3), .TICK_DIV(2), .WDOG_CYC(255)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .vsync(vsync_b), .pause(1'b0),
    .frog_req(frog_req_b), .frog_ack(frog_ack_b), .lane_req(lane_req_b), .lane_idx(lane_idx_b),
    .lane_ack(lane_ack_b), .collide(1'b0), .busy(busy_b), .frame_done(frame_done_b),
    .hit(hit_b), .overrun(overrun_b), .tick_cnt(tick_cnt_b)
`ifdef FRAME_UPDATE_WATCHDOG_EN
    , .wdog_err(wdog_err_b)
`endif
  );

  typedef struct {
    int   tick;
    logic hit;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ack/collide responder for instance A
  int stall_idx    = -1;
  int stall_left   = 0;
  bit frog_block   = 1'b0;
  bit arm_collide  = 1'b0;
  bit pend_collide = 1'b0;

  initial begin
    frog_ack_a = 1'b0;
    lane_ack_a = 1'b0;
    collide_a  = 1'b0;
    forever begin
      @(posedge clk); #1;
      collide_a    = pend_collide;
      pend_collide = 1'b0;
      frog_ack_a   = frog_req_a && !frog_ack_a && !frog_block;
      if (lane_req_a && !lane_ack_a && int'(lane_idx_a) == stall_idx && stall_left > 0) begin
        stall_left--;
        lane_ack_a = 1'b0;
      end else begin
        lane_ack_a = lane_req_a && !lane_ack_a;
      end
      if (lane_ack_a && lane_idx_a == 3'd7) pend_collide = arm_collide;
    end
  end

  // ack responder for instance B
  initial begin
    frog_ack_b = 1'b0;
    lane_ack_b = 1'b0;
    forever begin
      @(posedge clk); #1;
      frog_ack_b = frog_req_b && !frog_ack_b;
      lane_ack_b = lane_req_b && !lane_ack_b;
    end
  end

  // monitor for instance A
  int   lane_exp     = 99;
  int   lane3_cycles = 0;
  bit   prev_hold    = 1'b0;
  int   prev_idx     = 0;
  exp_t e;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lane_exp  = 99;
        prev_hold = 1'b0;
      end else begin
        if (frog_req_a) lane_exp = 0;
        if (lane_req_a && lane_idx_a == 3'd3) lane3_cycles++;
        if (prev_hold && lane_req_a) check("lane_idx_stable", int'(lane_idx_a), prev_idx);
        prev_hold = lane_req_a && !lane_ack_a;
        prev_idx  = int'(lane_idx_a);
        if (lane_req_a && lane_ack_a) begin
          check("lane_order", int'(lane_idx_a), lane_exp);
          lane_exp++;
        end
        if (frame_done_a) begin
          if (sb.size() == 0) begin
            check("unexpected_frame_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("tick_cnt", int'(tick_cnt_a), e.tick);
            check("hit", int'(hit_a), int'(e.hit));
            check("lanes_done", lane_exp, 8);
          end
        end
      end
    end
  end

  // monitor for instance B
  int fd_b = 0;
  initial forever begin
    @(negedge clk);
    if (frame_done_b) fd_b++;
  end

  task automatic fall_a();
    @(negedge clk) vsync_a = 1'b0;
    repeat (3) @(negedge clk);
    vsync_a = 1'b1;
  endtask

  task automatic fall_b();
    @(negedge clk) vsync_b = 1'b0;
    repeat (3) @(negedge clk);
    vsync_b = 1'b1;
  endtask

  task automatic expect_seq(input int tick, input logic h);
    exp_t x;
    x.tick = tick;
    x.hit  = h;
    sb.push_back(x);
  endtask

  task automatic wait_lane(input int idx, input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lane_req_a && int'(lane_idx_a) == idx) break;
    end
    check(name, int'(i < 200), 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    pause   = 1'b0;
    vsync_a = 1'b1;
    vsync_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_frog_req", int'(frog_req_a), 0);
    check("rst_lane_req", int'(lane_req_a), 0);
    check("rst_lane_idx", int'(lane_idx_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_frame_done", int'(frame_done_a), 0);
    check("rst_hit", int'(hit_a), 0);
    check("rst_overrun", int'(overrun_a), 0);
    check("rst_tick_cnt", int'(tick_cnt_a), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // divide-by-2: four falls give two sequences
    for (int k = 0; k < 4; k++) begin
      fall_b();
      repeat (40) @(negedge clk);
    end
    check("div2_sequences", fd_b, 2);
    check("div2_tick_cnt", int'(tick_cnt_b), 2);

    // every fall runs one sequence
    for (int k = 1; k <= 3; k++) begin
      expect_seq(k, 1'b0);
      fall_a();
      repeat (40) @(negedge clk);
    end
    check("seq3_tick_cnt", int'(tick_cnt_a), 3);

    // pause suppresses the tick
    pause = 1'b1;
    fall_a();
    repeat (40) @(negedge clk);
    pause = 1'b0;
    check("pause_tick_cnt", int'(tick_cnt_a), 3);

    // lane 3 ack withheld for 20 cycles
    lane3_cycles = 0;
    stall_idx    = 3;
    stall_left   = 20;
    expect_seq(4, 1'b0);
    fall_a();
    repeat (60) @(negedge clk);
    check("lane3_req_cycles", lane3_cycles, 21);
    check("overrun_clear", int'(overrun_a), 0);

    // second fall while stalled on lane 5 is dropped
    stall_idx  = 5;
    stall_left = 30;
    expect_seq(5, 1'b0);
    fall_a();
    wait_lane(5, "reach_lane5");
    fall_a();
    repeat (80) @(negedge clk);
    check("overrun_set", int'(overrun_a), 1);
    check("no_extra_seq", int'(tick_cnt_a), 5);
    stall_idx = -1;

    // collide only in CHECK, then a clean sequence
    arm_collide = 1'b1;
    expect_seq(6, 1'b1);
    fall_a();
    repeat (40) @(negedge clk);
    arm_collide = 1'b0;
    expect_seq(7, 1'b0);
    fall_a();
    repeat (40) @(negedge clk);

    // reset in lane 4 aborts the sequence
    fall_a();
    wait_lane(4, "reach_lane4");
    rst_n = 1'b0;
    #1;
    check("abort_lane_req", int'(lane_req_a), 0);
    check("abort_frog_req", int'(frog_req_a), 0);
    check("abort_busy", int'(busy_a), 0);
    check("abort_frame_done", int'(frame_done_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_overrun", int'(overrun_a), 0);
    expect_seq(1, 1'b0);
    fall_a();
    repeat (40) @(negedge clk);

`ifdef FRAME_UPDATE_WATCHDOG_EN
    begin
      int i;
      int frog_cycles;
      frog_block  = 1'b1;
      frog_cycles = 0;
      expect_seq(2, 1'b0);
      fall_a();
      for (i = 0; i < 20 && !frog_req_a; i++) @(negedge clk);
      for (i = 0; i < 400 && frog_req_a; i++) begin
        frog_cycles++;
        @(negedge clk);
      end
      check("wdog_frog_cycles", frog_cycles, 255);
      check("wdog_err", int'(wdog_err_a), 1);
      frog_block = 1'b0;
      repeat (40) @(negedge clk);
    end
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
